// File: rtl/spi_slave_pkg.sv
`default_nettype none
// ============================================================================
// Package : spi_slave_pkg
// FSM state/phase types and 2-bit command encodings of the SPI slave.
// Rev     : 1.0
// ============================================================================
package spi_slave_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADDR,
        READ_DATA
    } state_e;

    typedef enum logic [1:0] {
        PH_RX,
        PH_WAIT,
        PH_TX
    } rd_phase_e;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage
`default_nettype wire

// File: rtl/spi_shift_reg_param.sv
`default_nettype none
// ============================================================================
// Module : spi_shift_reg_param
// MSB-first frame shifter (SIPO from MOSI, PISO to MISO) with bit counter.
// Rev    : 1.0
// ============================================================================
module spi_shift_reg_param #(
    parameter int DATA_W     = 8,
    parameter int FRAME_BITS = DATA_W + 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr,
    input  logic                  i_shift,
    input  logic                  i_load,
    input  logic                  i_bit,
    input  logic [DATA_W-1:0]     i_par,
    output logic [FRAME_BITS-1:0] o_frame,
    output logic                  o_tx_bit,
    output logic                  o_rx_done,
    output logic                  o_tx_done
);

    localparam int CNT_W = $clog2(DATA_W + 3);
    localparam int SR_W  = FRAME_BITS - 1;

    logic [SR_W-1:0]  r_sr;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_sr  <= SR_W'(i_par);
            r_cnt <= '0;
        end else if (i_shift) begin
            r_sr  <= {r_sr[SR_W-2:0], i_bit};
            r_cnt <= r_cnt + CNT_W'(1);
        end else if (i_clr) begin
            r_cnt <= '0;
        end
    end

    // The register holds all but the final bit; the final bit is taken live
    // so the complete frame is visible on the edge that samples it.
    assign o_frame   = {r_sr, i_bit};
    assign o_tx_bit  = r_sr[DATA_W-1];
    assign o_rx_done = (r_cnt == CNT_W'(FRAME_BITS - 1));
    assign o_tx_done = (r_cnt == CNT_W'(DATA_W));

endmodule
`default_nettype wire

// File: rtl/spi_slave_param.sv
`default_nettype none
// ============================================================================
// Module : spi_slave_param
// SPI slave front end for the RAM subsystem; optional trailing even-parity
// bit when SPI_SLAVE_RX_PARITY_EN is defined.
// Rev    : 1.0
// ============================================================================
module spi_slave_param
    import spi_slave_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              SCK,
    input  logic              rst,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              read_addr_received,
    output logic              seq_err
`ifdef SPI_SLAVE_RX_PARITY_EN
    ,
    output logic              rx_parity_err
`endif
);

`ifdef SPI_SLAVE_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int FRAME_BITS = DATA_W + 2 + PAR_BITS;

    state_e    r_state;
    rd_phase_e r_phase;

    logic [FRAME_BITS-1:0] w_frame;
    logic [DATA_W+1:0]     w_word;
    logic [1:0]            w_cmd;
    logic                  w_last;
    logic                  w_tx_done;
    logic                  w_tx_bit;
    logic                  w_par_ok;
    logic                  w_rx_active;
    logic                  w_shift;
    logic                  w_load;
    logic                  w_clr;

    assign w_word = w_frame[FRAME_BITS-1 -: DATA_W+2];
    assign w_cmd  = w_word[DATA_W+1:DATA_W];

`ifdef SPI_SLAVE_RX_PARITY_EN
    assign w_par_ok = ~^w_frame;
`else
    assign w_par_ok = 1'b1;
`endif

    assign w_rx_active = (r_state == WRITE) || (r_state == READ_ADDR) ||
                         ((r_state == READ_DATA) && (r_phase == PH_RX));
    assign w_shift = !SS_n && ((r_state == CHK_CMD) || w_rx_active ||
                               ((r_state == READ_DATA) && (r_phase == PH_TX)));
    assign w_load  = !SS_n && (r_state == READ_DATA) && (r_phase == PH_WAIT) && tx_valid;
    assign w_clr   = (r_state == IDLE);

    spi_shift_reg_param #(
        .DATA_W     (DATA_W),
        .FRAME_BITS (FRAME_BITS)
    ) u_shift (
        .clk       (SCK),
        .rst       (rst),
        .i_clr     (w_clr),
        .i_shift   (w_shift),
        .i_load    (w_load),
        .i_bit     (MOSI),
        .i_par     (tx_data),
        .o_frame   (w_frame),
        .o_tx_bit  (w_tx_bit),
        .o_rx_done (w_last),
        .o_tx_done (w_tx_done)
    );

    always_ff @(posedge SCK or posedge rst) begin
        if (rst) begin
            r_state            <= IDLE;
            r_phase            <= PH_RX;
            MISO               <= 1'b0;
            rx_data            <= '0;
            rx_valid           <= 1'b0;
            read_addr_received <= 1'b0;
            seq_err            <= 1'b0;
`ifdef SPI_SLAVE_RX_PARITY_EN
            rx_parity_err      <= 1'b0;
`endif
        end else begin
            rx_valid <= 1'b0;
            seq_err  <= 1'b0;
`ifdef SPI_SLAVE_RX_PARITY_EN
            rx_parity_err <= 1'b0;
`endif
            if (SS_n && (r_state != IDLE)) begin
                r_state <= IDLE;
                r_phase <= PH_RX;
                MISO    <= 1'b0;
            end else if (w_rx_active) begin
                if (w_last) begin
                    r_state <= IDLE;
                    r_phase <= PH_RX;
                    if (w_par_ok) begin
                        rx_valid <= 1'b1;
                        rx_data  <= w_word;
                        // rd-data without a pending rd-addr was decoded via READ_ADDR
                        case (w_cmd)
                            CMD_RD_ADDR: read_addr_received <= 1'b1;
                            CMD_RD_DATA: begin
                                if (r_state == READ_DATA) begin
                                    r_state <= READ_DATA;
                                    r_phase <= PH_WAIT;
                                end else begin
                                    seq_err <= 1'b1;
                                end
                            end
                            CMD_WR_ADDR, CMD_WR_DATA: ;
                        endcase
                    end
`ifdef SPI_SLAVE_RX_PARITY_EN
                    else begin
                        rx_parity_err <= 1'b1;
                    end
`endif
                end
            end else begin
                case (r_state)
                    IDLE: begin
                        if (!SS_n) r_state <= CHK_CMD;
                    end
                    CHK_CMD: begin
                        if (!MOSI)                   r_state <= WRITE;
                        else if (read_addr_received) r_state <= READ_DATA;
                        else                         r_state <= READ_ADDR;
                    end
                    READ_DATA: begin
                        if (r_phase == PH_WAIT) begin
                            if (tx_valid) r_phase <= PH_TX;
                        end else if (w_tx_done) begin
                            MISO               <= 1'b0;
                            read_addr_received <= 1'b0;
                            r_state            <= IDLE;
                            r_phase            <= PH_RX;
                        end else begin
                            MISO <= w_tx_bit;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_phase <= PH_RX;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_param.sv
`default_nettype none
// ============================================================================
// Module : tb_spi_slave_param
// Random SPI frame traffic checked against a transaction-level slave model.
// Rev    : 1.0
// ============================================================================
module tb_spi_slave_param;

`ifdef SPI_SLAVE_RX_PARITY_EN
    localparam int DW = 16;
    localparam int PB = 1;
`else
    localparam int DW = 8;
    localparam int PB = 0;
`endif
    localparam int FRAME = DW + 2 + PB;

    logic          SCK = 1'b0;
    logic          rst;
    logic          SS_n;
    logic          MOSI;
    logic          MISO;
    logic [DW+1:0] rx_data;
    logic          rx_valid;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          read_addr_received;
    logic          seq_err;
`ifdef SPI_SLAVE_RX_PARITY_EN
    logic          rx_parity_err;
    bit            inject_bad_par = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: pending read flag and last accepted word
    logic          m_flag;
    logic [DW+1:0] m_rx_data;

    always #5 SCK = ~SCK;

    spi_slave_param #(.DATA_W(DW)) dut (
        .SCK                (SCK),
        .rst                (rst),
        .SS_n               (SS_n),
        .MOSI               (MOSI),
        .MISO               (MISO),
        .rx_data            (rx_data),
        .rx_valid           (rx_valid),
        .tx_data            (tx_data),
        .tx_valid           (tx_valid),
        .read_addr_received (read_addr_received),
        .seq_err            (seq_err)
`ifdef SPI_SLAVE_RX_PARITY_EN
        ,
        .rx_parity_err      (rx_parity_err)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge SCK);
        #1;
    endtask

    task automatic noise();
        tx_valid = 1'($urandom_range(0, 1));
        tx_data  = DW'($urandom);
    endtask

    // One SS_n-delimited transaction. abort_at: bit index at which SS_n rises
    // (-1 none); tx_abort_at / rst_at: MISO bit index for abort / async reset.
    task automatic send_frame(input logic [1:0] cmd, input logic [DW-1:0] pl,
                              input int abort_at, input int tx_abort_at,
                              input int rst_at, input logic [DW-1:0] txd);
        logic [FRAME-1:0] bits;
        bit good, exp_seq, do_tx;
`ifdef SPI_SLAVE_RX_PARITY_EN
        bits = {cmd, pl, (^{cmd, pl}) ^ inject_bad_par};
        good = !inject_bad_par;
`else
        bits = {cmd, pl};
        good = 1'b1;
`endif
        exp_seq = good && (cmd == 2'b11) && !m_flag;
        do_tx   = good && (cmd == 2'b11) && m_flag;

        SS_n = 1'b0;
        MOSI = 1'($urandom_range(0, 1));
        noise();
        step();
        check_eq("rxv_start", rx_valid, 0);
        for (int i = 0; i < FRAME; i++) begin
            if (i == abort_at) begin
                SS_n = 1'b1;
                noise();
                step();
                check_eq("abort_rxv", rx_valid, 0);
                check_eq("abort_miso", MISO, 0);
                check_eq("abort_flag", read_addr_received, m_flag);
                return;
            end
            MOSI = bits[FRAME-1-i];
            noise();
            step();
            check_eq("rxv_edge", rx_valid, (i == FRAME - 1) && good);
            check_eq("seq_err", seq_err, (i == FRAME - 1) && exp_seq);
            check_eq("miso_rx", MISO, 0);
        end
        if (good) begin
            m_rx_data = {cmd, pl};
            if (cmd == 2'b10) m_flag = 1'b1;
        end
        check_eq("rx_data", rx_data, m_rx_data);
        check_eq("flag", read_addr_received, m_flag);
`ifdef SPI_SLAVE_RX_PARITY_EN
        check_eq("par_err", rx_parity_err, !good);
`endif
        if (do_tx) begin
            repeat ($urandom_range(0, 3)) begin
                tx_valid = 1'b0;
                step();
                check_eq("miso_wait", MISO, 0);
            end
            tx_valid = 1'b1;
            tx_data  = txd;
            step();
            check_eq("miso_load", MISO, 0);
            for (int i = 0; i < DW; i++) begin
                if (i == tx_abort_at) begin
                    SS_n = 1'b1;
                    noise();
                    step();
                    check_eq("txabort_miso", MISO, 0);
                    check_eq("txabort_flag", read_addr_received, m_flag);
                    return;
                end
                if (i == rst_at) begin
                    #2 rst = 1'b1;
                    #1;
                    check_eq("arst_miso", MISO, 0);
                    check_eq("arst_rxv", rx_valid, 0);
                    check_eq("arst_flag", read_addr_received, 0);
                    rst       = 1'b0;
                    m_flag    = 1'b0;
                    m_rx_data = '0;
                    check_eq("arst_rxdata", rx_data, m_rx_data);
                    SS_n = 1'b1;
                    noise();
                    return;
                end
                noise();
                step();
                check_eq("miso_bit", MISO, txd[DW-1-i]);
                check_eq("flag_tx", read_addr_received, m_flag);
            end
            noise();
            step();
            m_flag = 1'b0;
            check_eq("miso_end", MISO, 0);
            check_eq("flag_end", read_addr_received, m_flag);
        end
        SS_n = 1'b1;
        noise();
        step();
        check_eq("rxv_pulse", rx_valid, 0);
        check_eq("seq_pulse", seq_err, 0);
        check_eq("miso_idle", MISO, 0);
    endtask

    initial begin
        logic [1:0]    rcmd;
        logic [DW-1:0] rpl;
        logic [DW-1:0] rtx;
        int            ab;
        int            tab;

        rst       = 1'b1;
        SS_n      = 1'b1;
        MOSI      = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = '0;
        m_flag    = 1'b0;
        m_rx_data = '0;
        step();
        step();
        check_eq("rst_miso", MISO, 0);
        check_eq("rst_rxv", rx_valid, 0);
        check_eq("rst_rxdata", rx_data, 0);
        check_eq("rst_flag", read_addr_received, 0);
        check_eq("rst_seq", seq_err, 0);
        rst = 1'b0;
        step();

        send_frame(2'b00, DW'('hA5), -1, -1, -1, '0);
        send_frame(2'b10, DW'('h03), -1, -1, -1, '0);
        send_frame(2'b11, DW'($urandom), -1, -1, -1, DW'('hC3));
        send_frame(2'b11, DW'($urandom), -1, -1, -1, '0);
        send_frame(2'b00, DW'('h3C), 5, -1, -1, '0);
        send_frame(2'b01, DW'('h5A), -1, -1, -1, '0);
        send_frame(2'b10, DW'('h44), -1, -1, -1, '0);
        send_frame(2'b11, DW'($urandom), -1, -1, 3, DW'('hC3));
`ifdef SPI_SLAVE_RX_PARITY_EN
        inject_bad_par = 1'b1;
        send_frame(2'b01, DW'('h1234), -1, -1, -1, '0);
        inject_bad_par = 1'b0;
`endif

        for (int n = 0; n < 300; n++) begin
            rcmd = 2'($urandom);
            rpl  = DW'($urandom);
            rtx  = DW'($urandom);
            ab   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, FRAME - 1)) : -1;
            tab  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, DW - 1)) : -1;
`ifdef SPI_SLAVE_RX_PARITY_EN
            inject_bad_par = ($urandom_range(0, 3) == 0);
`endif
            send_frame(rcmd, rpl, ab, tab, -1, rtx);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
